traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Safety monitor and lamp driver on the far side of the `traffic_light_contoller` light buses. It samples the four 3-bit light outputs every cycle and checks them against junction safety rules: legal encoding, conflicting greens, legal transitions, minimum yellow time and a stall watchdog. Legal values pass to the physical lamp outputs. On the first violation it latches a fault and forces every lamp to flashing yellow until an operator clears the fault.

## Interface
- `YEL_MIN`, 3: minimum cycles a bus must show yellow before red.
- `STALL_MAX`, 200: consecutive unchanged samples (all four buses) that count as a stall.
- `FLASH_HALF`, 4: cycles per flash half-period in the fault state.
- All parameters must be at least 1 and less than 2^16. Internal counters are 16 bits.
- `clk`  in  1  single clock; everything samples on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `light_M1`, `light_MT`, `light_M2`, `light_S`  in  3 each  controller light buses. Encoding: red = 3'b100, yellow = 3'b010, green = 3'b001. All other codes are illegal.
- `fault_clr`  in  1  level request to clear a latched fault.
- `lamp_M1`, `lamp_MT`, `lamp_M2`, `lamp_S`  out  3 each  registered lamp drive, same encoding as the inputs.
- `fault`  out  1  registered; 1 while in FAULT.
- `fault_code`  out  5  registered cause bits:
  - [0] illegal code
  - [1] conflict
  - [2] illegal transition
  - [3] yellow short
  - [4] stall

## Operation
- **States:** INIT, MONITOR, FAULT.
- **Reset values:**
  - state = INIT, fault = 0, fault_code = 0.
  - All lamps = 3'b100.
  - Previous-sample registers = 3'b100.
  - Yellow, stall and flash counters = 0; flash phase = 1.
- **INIT:**
  - Lamps held at red. Previous-sample registers load the current inputs every cycle.
  - Goes to MONITOR on the first edge where all four inputs carry legal codes. No other checks run in INIT.
- **MONITOR:** checks are evaluated on the current inputs against the previous-sample registers.
  - Illegal code: any bus is not exactly one of the three legal codes.
  - Conflict: any of these pairs are green together: (S, M1), (S, M2), (S, MT), (MT, M2).
  - Illegal transition: per bus, only these are legal: hold, R→G, G→Y, Y→R. Anything else sets bit 2 (e.g. G→R, Y→G, R→Y).
  - Yellow short:
    - Each bus has a yellow counter. It counts cycles while the bus is yellow and saturates at `YEL_MIN`.
    - It is cleared when the bus is not yellow.
    - A Y→R transition with count < `YEL_MIN` sets bit 3.
  - Stall:
    - The stall counter increments each cycle all four buses equal their previous samples, and is cleared on any change.
    - After `STALL_MAX` consecutive unchanged samples, bit 4 is set.
  - Any set bit moves the block to FAULT. All checks firing in the same cycle are OR'd into `fault_code`.
  - With no violation, each lamp register loads its input bus.
- **FAULT:**
  - `fault_code` is frozen; later violations add no bits.
  - Flash:
    - The flash counter runs from 0 to `FLASH_HALF`-1, then wraps and toggles the phase.
    - Phase 1: all lamps = 3'b010. Phase 0: all lamps = 3'b000.
    - Entry starts at phase 1 with the counter at 0.
  - `fault_clr` is accepted only on an edge where all four inputs are red; otherwise it is ignored.
  - On acceptance:
    - fault and `fault_code` clear.
    - Lamps go to 3'b100.
    - Previous-sample registers load the inputs; all counters are cleared.
    - State goes to MONITOR.
- **Reset mid-operation:** reset is asynchronous from any state. All outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Pass-through latency is 1 cycle: an input sampled at edge N appears on the lamps after edge N.
- Fault and lamp registers update on the same edge. The offending value never reaches the lamps: at edge N, fault rises, `fault_code` is valid and the lamps show 3'b010.
- The first flash phase lasts `FLASH_HALF` cycles; every phase after that also lasts `FLASH_HALF`.
- In the clear cycle (`fault_clr` accepted at edge N), fault = 0 after edge N. Pass-through resumes from edge N+1.
- `fault_clr` has no effect in INIT or MONITOR.

## Test plan
- **Reset exit and pass-through:** hold `rst`=0, then release with all inputs at 3'b100. Drive M1 green at edge 3 → `lamp_M1` = 3'b001 one cycle later, fault = 0.
- **Conflict:** drive S = 001 and M1 = 001 together at edge N → at edge N, fault = 1 and `fault_code` = 5'b00010. Lamps then show 010 for 4 cycles, 000 for 4 cycles, and repeat.
- **Illegal transition and illegal code:** M2 goes 001→100 → `fault_code` = 5'b00100. Separately, MT = 3'b011 → 5'b00001. Separately, M2 G→R while MT = 111 in the same cycle → 5'b00101.
- **Yellow short:** M1 sequence G, Y, Y, R → `fault_code` = 5'b01000. The sequence G, Y, Y, Y, R → no fault.
- **Stall and clear:** hold all inputs constant after MONITOR entry → fault with `fault_code` = 5'b10000 after the 200th unchanged sample. Pulse `fault_clr` with M1 green → still FAULT. Pulse `fault_clr` with all inputs red → fault = 0, lamps = 100, MONITOR.
- **Reset mid-fault:** assert `rst` low between clock edges while flashing → lamps = 100, fault = 0, `fault_code` = 0 with no clock edge needed. After release, INIT → MONITOR.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Safety monitor and lamp driver for the four junction light buses.
// Passes legal light values to the lamps and latches a flashing-yellow fault on any safety violation.
module traffic_light_monitor #(
    parameter int unsigned YEL_MIN    = 3,
    parameter int unsigned STALL_MAX  = 200,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [4:0] fault_code
);

    localparam logic [2:0]  RED = 3'b100;
    localparam logic [2:0]  YEL = 3'b010;
    localparam logic [2:0]  GRN = 3'b001;
    localparam logic [2:0]  OFF = 3'b000;
    localparam logic [15:0] YEL_MIN_C    = 16'(YEL_MIN);
    localparam logic [15:0] STALL_MAX_C  = 16'(STALL_MAX);
    localparam logic [15:0] FLASH_LAST_C = 16'(FLASH_HALF - 1);

    // Bus index: 0 = M1, 1 = MT, 2 = M2, 3 = S.
    localparam int M1 = 0;
    localparam int MT = 1;
    localparam int M2 = 2;
    localparam int S  = 3;

    typedef enum logic [1:0] {ST_INIT, ST_MONITOR, ST_FAULT} state_t;

    state_t           state_q;
    logic [3:0][2:0]  light_in;
    logic [3:0][2:0]  prev_q;
    logic [3:0][2:0]  lamp_q;
    logic [3:0][15:0] yel_cnt_q, yel_cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic [15:0]      flash_cnt_q;
    logic             flash_phase_q;
    logic             fault_q;
    logic [4:0]       code_q;
    logic [4:0]       viol;
    logic [3:0]       legal;
    logic [3:0]       green;
    logic             all_legal, all_red, unchanged;

    assign light_in = {light_S, light_M2, light_MT, light_M1};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        viol        = '0;
        legal       = '0;
        green       = '0;
        yel_cnt_d   = yel_cnt_q;
        all_legal   = 1'b1;
        all_red     = 1'b1;
        unchanged   = (light_in == prev_q);
        stall_cnt_d = unchanged ? stall_cnt_q + 16'd1 : 16'd0;

        for (int b = 0; b < 4; b++) begin
            legal[b] = (light_in[b] == RED) || (light_in[b] == YEL) || (light_in[b] == GRN);
            green[b] = (light_in[b] == GRN);
            if (!legal[b]) begin
                viol[0]   = 1'b1;
                all_legal = 1'b0;
            end
            if (light_in[b] != RED) all_red = 1'b0;

            // An illegal code is reported as such, not also as a bad transition.
            if (legal[b] && (light_in[b] != prev_q[b])) begin
                if (!((prev_q[b] == RED && light_in[b] == GRN) ||
                      (prev_q[b] == GRN && light_in[b] == YEL) ||
                      (prev_q[b] == YEL && light_in[b] == RED)))
                    viol[2] = 1'b1;
            end

            if (prev_q[b] == YEL && light_in[b] == RED && yel_cnt_q[b] < YEL_MIN_C)
                viol[3] = 1'b1;

            if (light_in[b] == YEL)
                yel_cnt_d[b] = (yel_cnt_q[b] >= YEL_MIN_C) ? YEL_MIN_C : yel_cnt_q[b] + 16'd1;
            else
                yel_cnt_d[b] = '0;
        end

        viol[1] = (green[S] && green[M1]) || (green[S] && green[M2]) ||
                  (green[S] && green[MT]) || (green[MT] && green[M2]);
        viol[4] = unchanged && (stall_cnt_d >= STALL_MAX_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            prev_q        <= {4{RED}};
            lamp_q        <= {4{RED}};
            yel_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
            fault_q       <= 1'b0;
            code_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            case (state_q)
                ST_INIT: begin
                    prev_q    <= light_in;
                    lamp_q    <= {4{RED}};
                    yel_cnt_q <= yel_cnt_d;
                    if (all_legal) state_q <= ST_MONITOR;
                end

                ST_MONITOR: begin
                    prev_q      <= light_in;
                    yel_cnt_q   <= yel_cnt_d;
                    stall_cnt_q <= stall_cnt_d;
                    if (|viol) begin
                        state_q       <= ST_FAULT;
                        fault_q       <= 1'b1;
                        code_q        <= viol;
                        lamp_q        <= {4{YEL}};
                        flash_cnt_q   <= '0;
                        flash_phase_q <= 1'b1;
                    end else begin
                        lamp_q <= light_in;
                    end
                end

                ST_FAULT: begin
                    if (fault_clr && all_red) begin
                        state_q       <= ST_MONITOR;
                        fault_q       <= 1'b0;
                        code_q        <= '0;
                        lamp_q        <= {4{RED}};
                        prev_q        <= light_in;
                        yel_cnt_q     <= '0;
                        stall_cnt_q   <= '0;
                        flash_cnt_q   <= '0;
                        flash_phase_q <= 1'b1;
                    end else if (flash_cnt_q >= FLASH_LAST_C) begin
                        flash_cnt_q   <= '0;
                        flash_phase_q <= ~flash_phase_q;
                        lamp_q        <= flash_phase_q ? {4{OFF}} : {4{YEL}};
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 16'd1;
                        lamp_q      <= flash_phase_q ? {4{YEL}} : {4{OFF}};
                    end
                end

                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign lamp_M1    = lamp_q[M1];
    assign lamp_MT    = lamp_q[MT];
    assign lamp_M2    = lamp_q[M2];
    assign lamp_S     = lamp_q[S];
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: expectations are queued as each input
// vector is driven and compared against the registered outputs after the edge.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;
    localparam logic [11:0] ALL_R = {R, R, R, R};
    localparam logic [11:0] ALL_Y = {Y, Y, Y, Y};
    localparam logic [11:0] ALL_O = {O, O, O, O};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] light_M1 = R, light_MT = R, light_M2 = R, light_S = R;
    logic       fault_clr = 1'b0;
    logic [2:0] lamp_M1, lamp_MT, lamp_M2, lamp_S;
    logic       fault;
    logic [4:0] fault_code;

    traffic_light_monitor #(
        .YEL_MIN   (3),
        .STALL_MAX (200),
        .FLASH_HALF(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .light_M1  (light_M1),
        .light_MT  (light_MT),
        .light_M2  (light_M2),
        .light_S   (light_S),
        .fault_clr (fault_clr),
        .lamp_M1   (lamp_M1),
        .lamp_MT   (lamp_MT),
        .lamp_M2   (lamp_M2),
        .lamp_S    (lamp_S),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lamps;
        logic        flt;
        logic [4:0]  code;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [11:0] l4(input logic [2:0] m1, input logic [2:0] mt,
                                       input logic [2:0] m2, input logic [2:0] s);
        return {s, m2, mt, m1};
    endfunction

    // Flash pattern k edges after fault entry with a half-period of 4.
    function automatic logic [11:0] flash_exp(input int k);
        return (((k / 4) % 2) == 0) ? ALL_Y : ALL_O;
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [11:0] el, input logic el_f,
                                 input logic [4:0] el_c);
        check({tag, "/lamps"}, {lamp_S, lamp_M2, lamp_MT, lamp_M1}, el);
        check({tag, "/fault"}, 12'(fault), 12'(el_f));
        check({tag, "/code"}, 12'(fault_code), 12'(el_c));
    endtask

    task automatic cyc(input string tag, input logic [2:0] m1, input logic [2:0] mt,
                       input logic [2:0] m2, input logic [2:0] s, input logic clr,
                       input logic [11:0] el, input logic ef, input logic [4:0] ec);
        exp_t e;
        light_M1  = m1;
        light_MT  = mt;
        light_M2  = m2;
        light_S   = s;
        fault_clr = clr;
        e.lamps = el;
        e.flt   = ef;
        e.code  = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_outputs(tag, e.lamps, e.flt, e.code);
    endtask

    task automatic clear_fault();
        cyc("clear", R, R, R, R, 1'b1, ALL_R, 1'b0, 5'b00000);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", ALL_R, 1'b0, 5'b00000);
        #2 rst = 1'b1;

        // Reset exit, pass-through and a legal yellow sequence on M1.
        cyc("init_exit", R, R, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);
        cyc("idle",      R, R, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);
        cyc("m1_grn",    G, R, R, R, 1'b0, l4(G, R, R, R), 1'b0, 5'b00000);
        cyc("m1_yel1",   Y, R, R, R, 1'b0, l4(Y, R, R, R), 1'b0, 5'b00000);
        cyc("m1_yel2",   Y, R, R, R, 1'b0, l4(Y, R, R, R), 1'b0, 5'b00000);
        cyc("m1_yel3",   Y, R, R, R, 1'b0, l4(Y, R, R, R), 1'b0, 5'b00000);
        cyc("m1_red",    R, R, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);

        // M1 and MT may be green together; fault_clr is ignored outside FAULT.
        cyc("m1_mt_grn", G, G, R, R, 1'b1, l4(G, G, R, R), 1'b0, 5'b00000);
        cyc("m1_mt_y1",  Y, Y, R, R, 1'b0, l4(Y, Y, R, R), 1'b0, 5'b00000);
        cyc("m1_mt_y2",  Y, Y, R, R, 1'b0, l4(Y, Y, R, R), 1'b0, 5'b00000);
        cyc("m1_mt_y3",  Y, Y, R, R, 1'b0, l4(Y, Y, R, R), 1'b0, 5'b00000);
        cyc("m1_mt_red", R, R, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);

        // Yellow held only two cycles before red.
        cyc("m2_grn",    R, R, G, R, 1'b0, l4(R, R, G, R), 1'b0, 5'b00000);
        cyc("m2_yel1",   R, R, Y, R, 1'b0, l4(R, R, Y, R), 1'b0, 5'b00000);
        cyc("m2_yel2",   R, R, Y, R, 1'b0, l4(R, R, Y, R), 1'b0, 5'b00000);
        cyc("yel_short", R, R, R, R, 1'b0, ALL_Y, 1'b1, 5'b01000);

        // Flashing; clear with M1 green and a later conflict must both be ignored.
        for (int k = 1; k < 12; k++) begin
            if (k == 1)
                cyc("flash_clr_ign", G, R, R, R, 1'b1, flash_exp(k), 1'b1, 5'b01000);
            else if (k == 2)
                cyc("flash_frozen", G, R, R, G, 1'b0, flash_exp(k), 1'b1, 5'b01000);
            else
                cyc("flash", R, R, R, R, 1'b0, flash_exp(k), 1'b1, 5'b01000);
        end
        clear_fault();

        cyc("conflict", G, R, R, G, 1'b0, ALL_Y, 1'b1, 5'b00010);
        for (int k = 1; k < 9; k++)
            cyc("conf_flash", R, R, R, R, 1'b0, flash_exp(k), 1'b1, 5'b00010);
        clear_fault();

        cyc("m2_go",   R, R, G, R, 1'b0, l4(R, R, G, R), 1'b0, 5'b00000);
        cyc("m2_g2r",  R, R, R, R, 1'b0, ALL_Y, 1'b1, 5'b00100);
        clear_fault();

        cyc("mt_011",  R, 3'b011, R, R, 1'b0, ALL_Y, 1'b1, 5'b00001);
        clear_fault();

        cyc("m2_go2",  R, R, G, R, 1'b0, l4(R, R, G, R), 1'b0, 5'b00000);
        cyc("g2r_ill", R, 3'b111, R, R, 1'b0, ALL_Y, 1'b1, 5'b00101);
        clear_fault();

        // Stall: the clear loaded red, so the 200th unchanged sample faults.
        for (int i = 1; i < 200; i++)
            cyc("stall_wait", R, R, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);
        cyc("stall",     R, R, R, R, 1'b0, ALL_Y, 1'b1, 5'b10000);
        cyc("clr_m1_g",  G, R, R, R, 1'b1, ALL_Y, 1'b1, 5'b10000);
        cyc("flash_k2",  R, R, R, R, 1'b0, ALL_Y, 1'b1, 5'b10000);
        clear_fault();
        cyc("after_clr", G, R, R, R, 1'b0, l4(G, R, R, R), 1'b0, 5'b00000);

        // Reset asserted between edges while flashing.
        cyc("refault",   G, R, R, G, 1'b0, ALL_Y, 1'b1, 5'b00010);
        cyc("refault_f", R, R, R, R, 1'b0, ALL_Y, 1'b1, 5'b00010);
        #2 rst = 1'b0;
        #1;
        check_outputs("async_rst", ALL_R, 1'b0, 5'b00000);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", ALL_R, 1'b0, 5'b00000);
        #3 rst = 1'b1;

        cyc("init_illegal", R, 3'b111, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);
        cyc("init_legal",   G, R, R, R, 1'b0, ALL_R, 1'b0, 5'b00000);
        cyc("mon_resume",   G, R, R, R, 1'b0, l4(G, R, R, R), 1'b0, 5'b00000);
        cyc("mon_yel",      Y, R, R, R, 1'b0, l4(Y, R, R, R), 1'b0, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
